// File: rtl/sv39_ptw.sv
// Sv39 hardware page-table walker: turns a virtual address into a physical address
// or a page fault by reading up to three PTEs over the data bus. No TLB, no A/D updates.

package sv39_ptw_pkg;
  typedef enum logic [2:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic [3:0]  mode;
    logic [15:0] asid;
    logic [43:0] ppn;
  } satp_t;

  typedef struct packed {
    logic [9:0]  reserved;
    logic [43:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } Sv39_entry_t;
endpackage

module sv39_ptw
  import sv39_ptw_pkg::*;
#(
  parameter logic [3:0] SV39_MODE = 4'd8,
  parameter logic [3:0] BARE_MODE = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_vaddr,
  input  logic        req_is_write,
  input  logic        req_is_fetch,
  input  satp_t       satp,
  input  logic [1:0]  priv,
  output logic        resp_valid,
  output logic [63:0] resp_paddr,
  output logic        resp_fault,
  output dbus_req_t   dreq,
  input  dbus_resp_t  dresp
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_n;
  logic [1:0]  level_q, level_n;
  logic [55:0] base_q, base_n;
  logic [38:0] va_q, va_n;
  logic        is_write_q, is_write_n;
  logic        is_fetch_q, is_fetch_n;
  logic [1:0]  priv_q, priv_n;
  logic [63:0] paddr_q, paddr_n;
  logic        fault_q, fault_n;

  Sv39_entry_t pte;
  logic [8:0]  vpn_sel;
  logic [55:0] pte_addr;
  logic        pte_arrive;
  logic        pte_fault;
  logic        pte_leaf;
  logic [55:0] pte_pa;
  logic        misaligned, perm_ok, user_ok, ad_ok;
  logic        canonical;
  logic        unused_bits;

  assign pte       = dresp.data;
  assign canonical = (req_vaddr[63:39] == {25{req_vaddr[38]}});
  assign unused_bits = ^{satp.asid, pte.reserved, pte.rsw, pte.g};

  always_comb begin
    case (level_q)
      2'd2:    vpn_sel = va_q[38:30];
      2'd1:    vpn_sel = va_q[29:21];
      default: vpn_sel = va_q[20:12];
    endcase
  end

  assign pte_addr   = base_q + {44'b0, vpn_sel, 3'b000};
  assign pte_arrive = ((state_q == REQ) && dresp.addr_ok && dresp.data_ok) ||
                      ((state_q == WAIT) && dresp.data_ok);

  assign misaligned = ((level_q == 2'd2) && (pte.ppn[17:0] != 18'd0)) ||
                      ((level_q == 2'd1) && (pte.ppn[8:0] != 9'd0));
  assign perm_ok    = is_fetch_q ? pte.x : (is_write_q ? pte.w : pte.r);
  assign user_ok    = (priv_q == 2'd0) ? pte.u : ((priv_q == 2'd1) ? !pte.u : 1'b1);
  assign ad_ok      = pte.a && (!is_write_q || pte.d);

  // Classify the returned PTE: invalid, pointer to the next level, or leaf.
  always_comb begin
    pte_fault = 1'b0;
    pte_leaf  = 1'b0;
    pte_pa    = '0;
    if (!pte.v || (!pte.r && pte.w)) begin
      pte_fault = 1'b1;
    end else if (!pte.r && !pte.x) begin
      pte_fault = (level_q == 2'd0);
    end else begin
      pte_leaf  = 1'b1;
      pte_fault = misaligned || !perm_ok || !user_ok || !ad_ok;
      case (level_q)
        2'd2:    pte_pa = {pte.ppn[43:18], va_q[29:21], va_q[20:12], va_q[11:0]};
        2'd1:    pte_pa = {pte.ppn[43:9], va_q[20:12], va_q[11:0]};
        default: pte_pa = {pte.ppn, va_q[11:0]};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      level_q    <= 2'd0;
      base_q     <= '0;
      va_q       <= '0;
      is_write_q <= 1'b0;
      is_fetch_q <= 1'b0;
      priv_q     <= 2'd0;
      paddr_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_n;
      level_q    <= level_n;
      base_q     <= base_n;
      va_q       <= va_n;
      is_write_q <= is_write_n;
      is_fetch_q <= is_fetch_n;
      priv_q     <= priv_n;
      paddr_q    <= paddr_n;
      fault_q    <= fault_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    level_n    = level_q;
    base_n     = base_q;
    va_n       = va_q;
    is_write_n = is_write_q;
    is_fetch_n = is_fetch_q;
    priv_n     = priv_q;
    paddr_n    = paddr_q;
    fault_n    = fault_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          va_n       = req_vaddr[38:0];
          is_write_n = req_is_write;
          is_fetch_n = req_is_fetch;
          priv_n     = priv;
          state_n    = DONE;
          if ((priv == 2'd3) || (satp.mode == BARE_MODE)) begin
            paddr_n = req_vaddr;
            fault_n = 1'b0;
          end else if ((satp.mode != SV39_MODE) || !canonical) begin
            paddr_n = '0;
            fault_n = 1'b1;
          end else begin
            level_n = 2'd2;
            base_n  = {satp.ppn, 12'h000};
            fault_n = 1'b0;
            state_n = REQ;
          end
        end
      end
      REQ:     if (dresp.addr_ok && !dresp.data_ok) state_n = WAIT;
      WAIT:    ;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (pte_arrive) begin
      if (pte_fault) begin
        state_n = DONE;
        fault_n = 1'b1;
        paddr_n = '0;
      end else if (pte_leaf) begin
        state_n = DONE;
        fault_n = 1'b0;
        paddr_n = {8'b0, pte_pa};
      end else begin
        state_n = REQ;
        level_n = level_q - 2'd1;
        base_n  = {pte.ppn, 12'h000};
      end
    end
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == DONE);
    resp_fault = resp_valid && fault_q;
    resp_paddr = (resp_valid && !fault_q) ? paddr_q : '0;
    dreq       = '0;
    if (state_q == REQ) begin
      dreq.valid = 1'b1;
      dreq.addr  = {8'b0, pte_addr};
      dreq.size  = MSIZE8;
    end
  end

endmodule

// File: tb/tb_sv39_ptw.sv
// Directed bench for sv39_ptw: a table of translations against a three-entry PTE memory,
// plus hand-written backpressure and mid-walk reset sequences.

module tb_sv39_ptw;
  import sv39_ptw_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_vaddr;
  logic        req_is_write;
  logic        req_is_fetch;
  satp_t       satp;
  logic [1:0]  priv;
  logic        resp_valid;
  logic [63:0] resp_paddr;
  logic        resp_fault;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;

  always #5 clk = ~clk;

  sv39_ptw dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_vaddr    (req_vaddr),
    .req_is_write (req_is_write),
    .req_is_fetch (req_is_fetch),
    .satp         (satp),
    .priv         (priv),
    .resp_valid   (resp_valid),
    .resp_paddr   (resp_paddr),
    .resp_fault   (resp_fault),
    .dreq         (dreq),
    .dresp        (dresp)
  );

  typedef struct {
    string       name;
    logic [63:0] vaddr;
    logic        wr;
    logic        fe;
    logic [1:0]  prv;
    logic [63:0] satp_v;
    logic [63:0] pte2;
    logic [63:0] pte1;
    logic [63:0] pte0;
    logic [63:0] exp_paddr;
    logic        exp_fault;
    int          exp_reads;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  // Memory model state: three PTE slots at the fixed addresses the walks use.
  logic [63:0] m2, m1, m0;
  int          addr_delay = 0;
  int          data_delay = 0;
  int          wait_cnt = 0;
  int          pend_cnt = 0;
  logic [63:0] pend_data;
  dbus_req_t   held;
  logic [63:0] read_log[$];
  int          valid_cycles = 0;
  int          stab_err = 0;
  int          field_err = 0;

  logic [63:0] exp_addr [3] = '{64'h80010008, 64'h80011008, 64'h80012008};

  function automatic logic [63:0] mem_read(input logic [63:0] a);
    case (a)
      64'h80010008: return m2;
      64'h80011008: return m1;
      64'h80012008: return m0;
      default:      return 64'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    dresp = '0;
    if (reset) begin
      pend_cnt = 0;
      wait_cnt = 0;
    end else begin
      if (pend_cnt > 0) begin
        pend_cnt = pend_cnt - 1;
        if (pend_cnt == 0) begin
          dresp.data_ok = 1'b1;
          dresp.data    = pend_data;
        end
      end
      if (dreq.valid) begin
        valid_cycles = valid_cycles + 1;
        if (dreq.size != MSIZE8 || dreq.strobe != 8'h0 || dreq.data != 64'h0)
          field_err = field_err + 1;
        if (wait_cnt == 0) held = dreq;
        else if (dreq != held) stab_err = stab_err + 1;
        if (wait_cnt == addr_delay) begin
          wait_cnt = 0;
          dresp.addr_ok = 1'b1;
          read_log.push_back(dreq.addr);
          if (data_delay == 0) begin
            dresp.data_ok = 1'b1;
            dresp.data    = mem_read(dreq.addr);
          end else begin
            pend_cnt  = data_delay;
            pend_data = mem_read(dreq.addr);
          end
        end else begin
          wait_cnt = wait_cnt + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one request, scrambles the inputs after acceptance, then checks result,
  // latency, PTE read sequence and the return to ready.
  task automatic applyStimulus(input vec_t v, input int exp_lat, input int exp_valid);
    int lat;
    bit got;
    m2 = v.pte2;
    m1 = v.pte1;
    m0 = v.pte0;
    read_log.delete();
    valid_cycles = 0;
    @(negedge clk);
    req_vaddr    = v.vaddr;
    req_is_write = v.wr;
    req_is_fetch = v.fe;
    priv         = v.prv;
    satp         = v.satp_v;
    req_valid    = 1'b1;
    checkOutput({v.name, ":ready_before"}, {63'b0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_vaddr    = 64'hFFFF_FFC0_DEAD_B000;
    req_is_write = ~v.wr;
    req_is_fetch = ~v.fe;
    priv         = 2'd3;
    satp         = 64'h0;
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 60 && !got; c++) begin
      if (resp_valid) begin
        got = 1'b1;
        lat = c;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    checkOutput({v.name, ":latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({v.name, ":fault"}, {63'b0, resp_fault}, {63'b0, v.exp_fault});
    checkOutput({v.name, ":paddr"}, resp_paddr, v.exp_paddr);
    checkOutput({v.name, ":ready_in_done"}, {63'b0, req_ready}, 64'd0);
    @(posedge clk);
    #1;
    checkOutput({v.name, ":pulse_end"}, {63'b0, resp_valid}, 64'd0);
    checkOutput({v.name, ":ready_after"}, {63'b0, req_ready}, 64'd1);
    checkOutput({v.name, ":reads"}, 64'(read_log.size()), 64'(v.exp_reads));
    checkOutput({v.name, ":valid_cycles"}, 64'(valid_cycles), 64'(exp_valid));
    for (int i = 0; i < read_log.size() && i < v.exp_reads; i++)
      checkOutput($sformatf("%s:read%0d_addr", v.name, i), read_log[i], exp_addr[i]);
  endtask

  localparam logic [63:0] VA   = 64'h40201ABC;
  localparam logic [63:0] S39  = 64'h8000_0000_0008_0010;
  localparam logic [63:0] P2   = 64'h20004401;
  localparam logic [63:0] P1   = 64'h20004801;
  localparam logic [63:0] LEAF = 64'h200400D7;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"walk4k",        VA, 1'b0, 1'b0, 2'd0, S39, P2, P1, LEAF,          64'h80100ABC, 1'b0, 3});
    vecs.push_back('{"giga_misalign", VA, 1'b0, 1'b0, 2'd0, S39, 64'h200044CF, P1, LEAF, 64'h0,       1'b1, 1});
    vecs.push_back('{"store_clean",   VA, 1'b1, 1'b0, 2'd0, S39, P2, P1, 64'h20040057,  64'h0,        1'b1, 3});
    vecs.push_back('{"bypass_m",      64'h80000000, 1'b0, 1'b0, 2'd3, S39, P2, P1, LEAF, 64'h80000000, 1'b0, 0});
    vecs.push_back('{"noncanon",      64'h0000008000000000, 1'b0, 1'b0, 2'd0, S39, P2, P1, LEAF, 64'h0, 1'b1, 0});
    vecs.push_back('{"bare",          64'h12345678, 1'b0, 1'b0, 2'd0, 64'h0000_0000_0008_0010, P2, P1, LEAF, 64'h12345678, 1'b0, 0});
    vecs.push_back('{"bad_mode",      VA, 1'b0, 1'b0, 2'd0, 64'h9000_0000_0008_0010, P2, P1, LEAF, 64'h0, 1'b1, 0});
    vecs.push_back('{"store_dirty",   VA, 1'b1, 1'b0, 2'd0, S39, P2, P1, LEAF,          64'h80100ABC, 1'b0, 3});
    vecs.push_back('{"fetch_nox",     VA, 1'b0, 1'b1, 2'd0, S39, P2, P1, LEAF,          64'h0,        1'b1, 3});
    vecs.push_back('{"fetch_x",       VA, 1'b0, 1'b1, 2'd0, S39, P2, P1, 64'h200400DB,  64'h80100ABC, 1'b0, 3});
    vecs.push_back('{"super_on_user", VA, 1'b0, 1'b0, 2'd1, S39, P2, P1, LEAF,          64'h0,        1'b1, 3});
    vecs.push_back('{"super_ok",      VA, 1'b0, 1'b0, 2'd1, S39, P2, P1, 64'h200400C7,  64'h80100ABC, 1'b0, 3});
    vecs.push_back('{"megapage",      VA, 1'b0, 1'b0, 2'd0, S39, P2, 64'h200800D7, LEAF, 64'h80201ABC, 1'b0, 2});
    vecs.push_back('{"gigapage",      VA, 1'b0, 1'b0, 2'd0, S39, 64'h200000D7, P1, LEAF, 64'h80201ABC, 1'b0, 1});
    vecs.push_back('{"nonleaf_l0",    VA, 1'b0, 1'b0, 2'd0, S39, P2, P1, 64'h20004C01,  64'h0,        1'b1, 3});
    vecs.push_back('{"invalid_l2",    VA, 1'b0, 1'b0, 2'd0, S39, 64'h0, P1, LEAF,       64'h0,        1'b1, 1});
    vecs.push_back('{"w_without_r",   VA, 1'b0, 1'b0, 2'd0, S39, P2, P1, 64'h200400D5,  64'h0,        1'b1, 3});
    vecs.push_back('{"accessed_clr",  VA, 1'b0, 1'b0, 2'd0, S39, P2, P1, 64'h20040097,  64'h0,        1'b1, 3});

    reset        = 1'b1;
    req_valid    = 1'b0;
    req_vaddr    = '0;
    req_is_write = 1'b0;
    req_is_fetch = 1'b0;
    satp         = '0;
    priv         = 2'd0;
    m2 = '0; m1 = '0; m0 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset:req_ready", {63'b0, req_ready}, 64'd1);
    checkOutput("reset:resp_valid", {63'b0, resp_valid}, 64'd0);
    checkOutput("reset:resp_paddr", resp_paddr, 64'd0);
    checkOutput("reset:resp_fault", {63'b0, resp_fault}, 64'd0);
    checkOutput("reset:dreq_zero", {63'b0, (dreq == '0)}, 64'd1);
    reset = 1'b0;

    foreach (vecs[i])
      applyStimulus(vecs[i], vecs[i].exp_reads + 1, vecs[i].exp_reads);

    // Backpressure: three cycles without addr_ok per read, data two cycles later.
    addr_delay = 3;
    data_delay = 2;
    stab_err   = 0;
    applyStimulus(vecs[0], 19, 12);
    checkOutput("backpressure:dreq_stable", 64'(stab_err), 64'd0);
    addr_delay = 0;

    // Reset while the walker waits for PTE data.
    data_delay = 3;
    m2 = P2; m1 = P1; m0 = LEAF;
    @(negedge clk);
    req_vaddr = VA; req_is_write = 1'b0; req_is_fetch = 1'b0; priv = 2'd0; satp = S39;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset:in_wait_dreq", {63'b0, dreq.valid}, 64'd0);
    checkOutput("midreset:in_wait_ready", {63'b0, req_ready}, 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset:req_ready", {63'b0, req_ready}, 64'd1);
    checkOutput("midreset:resp_valid", {63'b0, resp_valid}, 64'd0);
    checkOutput("midreset:resp_paddr", resp_paddr, 64'd0);
    checkOutput("midreset:resp_fault", {63'b0, resp_fault}, 64'd0);
    checkOutput("midreset:dreq_zero", {63'b0, (dreq == '0)}, 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    data_delay = 0;
    applyStimulus(vecs[3], 1, 0);

    checkOutput("dreq_fields", 64'(field_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
